// File: rtl/adf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adf_pkg
// Purpose  : Shared defaults and types for the adaptive-filter tap datapath.
// Revision : 1.0
// ============================================================================
package adf_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int TAPS_DEF   = 8;
    localparam int IDX_W      = $clog2(TAPS_DEF);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/tap_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tap_ring_buffer
// Purpose  : TAPS-deep circular sample history, read combinationally by delay.
// Revision : 1.0
// ============================================================================
module tap_ring_buffer
    import adf_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  TAPS   = TAPS_DEF,
    localparam int AW     = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic        [AW-1:0]     i_dly,
    output logic signed [DATA_W-1:0] o_rdata
);

    localparam int            SW       = AW + 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(TAPS - 1);

    logic signed [DATA_W-1:0] r_buf [TAPS];
    logic        [AW-1:0]     r_wr_ptr;
    logic        [SW-1:0]     w_raw;
    logic        [AW-1:0]     w_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_we) begin
            r_buf[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
        end
    end

    // (wr_ptr-1-dly) mod TAPS without a divider: bias by TAPS, fold once.
    always_comb begin
        w_raw  = {1'b0, r_wr_ptr} + SW'(TAPS - 1) - {1'b0, i_dly};
        w_addr = (w_raw >= SW'(TAPS)) ? AW'(w_raw - SW'(TAPS)) : AW'(w_raw);
    end

    assign o_rdata = r_buf[w_addr];

endmodule
`default_nettype wire

// File: rtl/tap_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tap_serializer
// Purpose  : Stores one sample per handshake, then streams the TAPS-deep tap
//            vector one tap per handshake. TAP_SERIALIZER_REV_ORDER_EN selects
//            oldest-first emission.
// Revision : 1.0
// ============================================================================
module tap_serializer
    import adf_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  TAPS   = TAPS_DEF,
    localparam int TIDX_W = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic signed [DATA_W-1:0] tap_data,
    output logic        [TIDX_W-1:0] tap_idx,
    output logic                     tap_last
);

`ifdef TAP_SERIALIZER_REV_ORDER_EN
    localparam logic [TIDX_W-1:0] FIRST_IDX = TIDX_W'(TAPS - 1);
    localparam logic [TIDX_W-1:0] LAST_IDX  = '0;
`else
    localparam logic [TIDX_W-1:0] FIRST_IDX = '0;
    localparam logic [TIDX_W-1:0] LAST_IDX  = TIDX_W'(TAPS - 1);
`endif

    state_t                   r_state;
    logic        [TIDX_W-1:0] r_idx;
    logic        [TIDX_W-1:0] w_idx_next;
    logic                     w_accept;
    logic                     w_tap_hs;
    logic signed [DATA_W-1:0] w_rdata;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_tap_hs = (r_state == ST_EMIT) && tap_ready;

`ifdef TAP_SERIALIZER_REV_ORDER_EN
    assign w_idx_next = r_idx - TIDX_W'(1);
`else
    assign w_idx_next = r_idx + TIDX_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_EMIT;
                        r_idx   <= FIRST_IDX;
                    end
                end
                ST_EMIT: begin
                    if (w_tap_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= w_idx_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    tap_ring_buffer #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_wdata (in),
        .i_dly   (r_idx),
        .o_rdata (w_rdata)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign tap_valid = (r_state == ST_EMIT);
    assign tap_idx   = r_idx;
    assign tap_last  = tap_valid && (r_idx == LAST_IDX);
    // Idle output is forced to zero so the post-reset tap_data is defined.
    assign tap_data  = tap_valid ? w_rdata : '0;

endmodule
`default_nettype wire
